// File: rtl/alu_seq_core.sv
// Handshaked ALU: single-cycle logic/add/sub/compare, iterative shift-add multiply and
// restoring divide. The result is held on a valid/ready output until it is consumed.
module alu_seq_core #(
    parameter int unsigned W   = 8,
    parameter int unsigned OPW = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   result,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_dbz,
    output logic             busy
);

    localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;

    localparam logic [OPW-1:0] OpCmp = OPW'(0);
    localparam logic [OPW-1:0] OpAdd = OPW'(1);
    localparam logic [OPW-1:0] OpSub = OPW'(2);
    localparam logic [OPW-1:0] OpMul = OPW'(3);
    localparam logic [OPW-1:0] OpDiv = OPW'(4);
    localparam logic [OPW-1:0] OpAnd = OPW'(5);
    localparam logic [OPW-1:0] OpOr  = OPW'(6);
    localparam logic [OPW-1:0] OpXor = OPW'(7);

    typedef enum logic [1:0] {StIdle, StExec, StDone} stateT;

    stateT          state;
    logic [OPW-1:0] opQ;
    logic [W-1:0]   aQ;
    logic [W-1:0]   bQ;
    logic [2*W-1:0] accQ;
    logic [CW-1:0]  cntQ;
    logic           lastQ;

    logic [2*W-1:0] quickRes;
    logic           quickCarry;
    logic           quickDbz;
    logic           isIter;
    logic [W:0]     addSum;

    logic [W:0]     mulSum;
    logic [2*W-1:0] mulNext;
    logic [W:0]     divShift;
    logic [W:0]     divSub;
    logic           divGe;
    logic [2*W-1:0] divNext;

    // Results for ops that finish in the accepting cycle, straight from the inputs.
    always_comb begin
        quickRes   = '0;
        quickCarry = 1'b0;
        quickDbz   = 1'b0;
        addSum     = {1'b0, a} + {1'b0, b};
        isIter     = (op == OpMul) || ((op == OpDiv) && (b != '0));
        case (op)
            OpCmp: quickRes = {{(2*W-3){1'b0}}, a > b, a == b, a < b};
            OpAdd: begin
                quickRes   = {{(W-1){1'b0}}, addSum};
                quickCarry = addSum[W];
            end
            OpSub: begin
                quickRes   = {{W{1'b0}}, a - b};
                quickCarry = a < b;
            end
            OpDiv: begin
                quickRes = {a, {W{1'b1}}};
                quickDbz = 1'b1;
            end
            OpAnd:   quickRes = {{W{1'b0}}, a & b};
            OpOr:    quickRes = {{W{1'b0}}, a | b};
            OpXor:   quickRes = {{W{1'b0}}, a ^ b};
            default: quickRes = '0;
        endcase
    end

    // One iteration step. accQ holds {partial, multiplier} for MUL and
    // {remainder, dividend/quotient} for DIV.
    always_comb begin
        mulSum   = {1'b0, accQ[2*W-1:W]} + (accQ[0] ? {1'b0, aQ} : '0);
        mulNext  = {mulSum, accQ[W-1:1]};
        divShift = {accQ[2*W-1:W], accQ[W-1]};
        divSub   = divShift - {1'b0, bQ};
        // Shifted remainder is below 2*b, so bit W of the difference is the borrow.
        divGe    = ~divSub[W];
        divNext  = {divGe ? divSub[W-1:0] : divShift[W-1:0], accQ[W-2:0], divGe};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_dbz   <= 1'b0;
            opQ        <= '0;
            aQ         <= '0;
            bQ         <= '0;
            accQ       <= '0;
            cntQ       <= '0;
            lastQ      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        opQ      <= op;
                        aQ       <= a;
                        bQ       <= b;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (isIter) begin
                            state <= StExec;
                            cntQ  <= CW'(W - 1);
                            lastQ <= 1'b0;
                            accQ  <= (op == OpMul) ? {{W{1'b0}}, b} : {{W{1'b0}}, a};
                        end else begin
                            state      <= StDone;
                            out_valid  <= 1'b1;
                            result     <= quickRes;
                            flag_zero  <= (quickRes == '0);
                            flag_carry <= quickCarry;
                            flag_dbz   <= quickDbz;
                        end
                    end
                end
                StExec: begin
                    // W iteration cycles, then one cycle to register the result.
                    if (lastQ) begin
                        state      <= StDone;
                        out_valid  <= 1'b1;
                        result     <= accQ;
                        flag_zero  <= (accQ == '0);
                        flag_carry <= 1'b0;
                        flag_dbz   <= 1'b0;
                        lastQ      <= 1'b0;
                    end else begin
                        accQ <= (opQ == OpMul) ? mulNext : divNext;
                        if (cntQ == '0) begin
                            lastQ <= 1'b1;
                        end else begin
                            cntQ <= cntQ - CW'(1);
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state     <= StIdle;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
